// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared definitions for the miniLA immediate-extension stage.
//   imm_op_t     : 3-bit extension-op encoding carried on in_op
//   IMM_OP_*     : the eight extension formats understood by imm_ext_stage
// -----------------------------------------------------------------------------
package imm_ext_pkg;

    typedef logic [2:0] imm_op_t;

    localparam imm_op_t IMM_OP_NONE   = 3'd0;  // constant zero
    localparam imm_op_t IMM_OP_SI12   = 3'd1;  // sext inst[21:10]
    localparam imm_op_t IMM_OP_UI12   = 3'd2;  // zext inst[21:10]
    localparam imm_op_t IMM_OP_SI16S2 = 3'd3;  // sext {inst[25:10],2'b0}
    localparam imm_op_t IMM_OP_SI26S2 = 3'd4;  // sext {inst[9:0],inst[25:10],2'b0}
    localparam imm_op_t IMM_OP_SI20U  = 3'd5;  // sext {inst[24:5],12'b0}
    localparam imm_op_t IMM_OP_UISH   = 3'd6;  // zext shift amount
    localparam imm_op_t IMM_OP_SI14S2 = 3'd7;  // sext {inst[23:10],2'b0}

endpackage

// File: rtl/imm_ext_stage_if.sv
// -----------------------------------------------------------------------------
// imm_ext_stage_if
// Handshake bundle for the immediate-extension stage.
//   in_valid/in_ready/in_op/in_inst/in_tag : upstream (IF/ID side) transfer
//   out_valid/out_ready/out_imm/out_tag    : downstream (ID/EX side) transfer
//   out_target                             : PC-relative target, only when
//                                            IMM_EXT_PCREL_EN is defined
// Modports: master = the side driving instructions in and consuming results,
//           slave  = the stage itself.
// -----------------------------------------------------------------------------
interface imm_ext_stage_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 32
);
    import imm_ext_pkg::*;

    logic              in_valid;
    logic              in_ready;
    imm_op_t           in_op;
    logic [31:0]       in_inst;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic [TAG_W-1:0]  out_tag;
`ifdef IMM_EXT_PCREL_EN
    logic [DATA_W-1:0] out_target;

    modport master (
        output in_valid, in_op, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_target
    );
    modport slave (
        input  in_valid, in_op, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_target
    );
`else
    modport master (
        output in_valid, in_op, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag
    );
    modport slave (
        input  in_valid, in_op, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag
    );
`endif

endinterface

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Generic two-entry valid/ready skid buffer with synchronous flush.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   flush     : drop every held entry at the next edge
//   in_valid  / in_ready  / in_data  : upstream transfer
//   out_valid / out_ready / out_data : downstream transfer (main entry)
// The main entry drives the outputs; the skid entry catches the one word that
// arrives while main is stalled. in_ready depends only on registered state so
// there is no combinational path from out_ready back to in_ready.
// -----------------------------------------------------------------------------
module pipe_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Occupancy: EMPTY (no entry), ONE (main only), TWO (main + skid).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]   state_reg, state_next;
    logic [W-1:0] main_reg,  main_next;
    logic [W-1:0] skid_reg,  skid_next;
    logic         accept;
    logic         drain;

    assign in_ready  = (state_reg != ST_TWO);
    assign out_valid = (state_reg != ST_EMPTY);
    assign out_data  = main_reg;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    main_next  = in_data;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    // Streaming: new word replaces the one leaving.
                    main_next = in_data;
                end else if (accept) begin
                    // Main is stalled; park the newcomer behind it.
                    skid_next  = in_data;
                    state_next = ST_TWO;
                end else if (drain) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    main_next  = skid_reg;
                    state_next = ST_ONE;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
        // Flush overrides any simultaneous accept or drain.
        if (flush) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

endmodule

// File: rtl/imm_ext_stage.sv
// -----------------------------------------------------------------------------
// imm_ext_stage
// Registered immediate-extension stage of the miniLA decode path. Decodes the
// extension op against the raw instruction word, and registers the DATA_W-bit
// immediate together with its tag in a two-entry skid buffer.
//   cpu_clk   : clock, rising edge
//   cpu_rst_n : asynchronous active-low reset
//   flush     : synchronous flush, drops all held entries
//   bus       : imm_ext_stage_if.slave (in_* upstream, out_* downstream)
// Parameters: DATA_W (32 or 64 only), TAG_W (sideband/PC width).
// Optional feature: define IMM_EXT_PCREL_EN to add out_target = tag + imm for
// the PC-relative ops (SI16S2, SI26S2, SI20U); it is computed before the
// register and stored with each entry.
// -----------------------------------------------------------------------------
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 32
) (
    input  logic           cpu_clk,
    input  logic           cpu_rst_n,
    input  logic           flush,
    imm_ext_stage_if.slave bus
);

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $error("imm_ext_stage: DATA_W must be 32 or 64");
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Combinational extender. Everything is built at 64 bits and then
    // truncated; truncating a 64-bit sign extension gives the 32-bit one.
    // ---------------------------------------------------------------------
    logic [31:0]       inst;
    logic [5:0]        shamt;
    logic [63:0]       imm_wide;
    logic [DATA_W-1:0] imm_ext;

    assign inst = bus.in_inst;

    // Shift amount field is one bit wider on the 64-bit datapath.
    assign shamt = (DATA_W == 64) ? inst[15:10] : {1'b0, inst[14:10]};

    always_comb begin
        imm_wide = '0;
        case (bus.in_op)
            IMM_OP_SI12:   imm_wide = {{52{inst[21]}}, inst[21:10]};
            IMM_OP_UI12:   imm_wide = {52'd0, inst[21:10]};
            IMM_OP_SI16S2: imm_wide = {{46{inst[25]}}, inst[25:10], 2'b00};
            IMM_OP_SI26S2: imm_wide = {{36{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
            IMM_OP_SI20U:  imm_wide = {{32{inst[24]}}, inst[24:5], 12'd0};
            IMM_OP_UISH:   imm_wide = {58'd0, shamt};
            IMM_OP_SI14S2: imm_wide = {{48{inst[23]}}, inst[23:10], 2'b00};
            default:       imm_wide = '0;
        endcase
    end

    assign imm_ext = imm_wide[DATA_W-1:0];

    // Opcode bits and (for 32-bit builds) the upper extension bits are
    // intentionally not consumed.
    logic unused_bits;
    assign unused_bits = ^{imm_wide, inst[31:26]};

`ifdef IMM_EXT_PCREL_EN
    // ---------------------------------------------------------------------
    // PC-relative target, wrapping modulo 2^DATA_W.
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] tag_zext;
    logic [DATA_W-1:0] target;
    logic              is_pcrel;

    generate
        if (TAG_W >= DATA_W) begin : g_tag_trunc
            assign tag_zext = bus.in_tag[DATA_W-1:0];
        end else begin : g_tag_pad
            assign tag_zext = {{(DATA_W-TAG_W){1'b0}}, bus.in_tag};
        end
    endgenerate

    assign is_pcrel = (bus.in_op == IMM_OP_SI16S2) ||
                      (bus.in_op == IMM_OP_SI26S2) ||
                      (bus.in_op == IMM_OP_SI20U);
    assign target   = is_pcrel ? (tag_zext + imm_ext) : '0;

    localparam int W = DATA_W + TAG_W + DATA_W;
    logic [W-1:0] in_data;
    logic [W-1:0] out_data;

    assign in_data        = {target, bus.in_tag, imm_ext};
    assign bus.out_imm    = out_data[DATA_W-1:0];
    assign bus.out_tag    = out_data[DATA_W +: TAG_W];
    assign bus.out_target = out_data[DATA_W+TAG_W +: DATA_W];
`else
    localparam int W = DATA_W + TAG_W;
    logic [W-1:0] in_data;
    logic [W-1:0] out_data;

    assign in_data     = {bus.in_tag, imm_ext};
    assign bus.out_imm = out_data[DATA_W-1:0];
    assign bus.out_tag = out_data[DATA_W +: TAG_W];
`endif

    // ---------------------------------------------------------------------
    // Storage: main + skid entries with flush.
    // ---------------------------------------------------------------------
    pipe_skid_buf #(
        .W (W)
    ) u_skid (
        .clk       (cpu_clk),
        .rst_n     (cpu_rst_n),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_imm_ext_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_stage
// Self-checking bench for imm_ext_stage (DATA_W=32, TAG_W=32). Accepted inputs
// push an expected result computed arithmetically from the format rules; an
// independent monitor pops and compares whenever an output transfer happens.
// Directed sections cover reset, latency, backpressure, flush and async reset;
// a randomized section streams ops with random out_ready. Target checks are
// included when IMM_EXT_PCREL_EN is defined.
// -----------------------------------------------------------------------------
module tb_imm_ext_stage;
    import imm_ext_pkg::*;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 32;

    logic cpu_clk   = 1'b0;
    logic cpu_rst_n = 1'b0;
    logic flush     = 1'b0;

    always #5 cpu_clk = ~cpu_clk;

    imm_ext_stage_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    imm_ext_stage #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .flush     (flush),
        .bus       (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] target;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // ---------------------------------------------------------------------
    // Reference model: field value as a signed integer, then wrap to DATA_W.
    // ---------------------------------------------------------------------
    function automatic longint sfield(longint raw, int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (raw >= half) ? (raw - 2 * half) : raw;
    endfunction

    function automatic longint ref_val(logic [2:0] op, logic [31:0] inst);
        longint v;
        v = 0;
        case (op)
            IMM_OP_SI12:   v = sfield(longint'(inst[21:10]), 12);
            IMM_OP_UI12:   v = longint'(inst[21:10]);
            IMM_OP_SI16S2: v = sfield(longint'(inst[25:10]), 16) * 4;
            IMM_OP_SI26S2: v = sfield(longint'({inst[9:0], inst[25:10]}), 26) * 4;
            IMM_OP_SI20U:  v = sfield(longint'(inst[24:5]), 20) * 4096;
            IMM_OP_UISH:   v = (DATA_W == 64) ? longint'(inst[15:10]) : longint'(inst[14:10]);
            IMM_OP_SI14S2: v = sfield(longint'(inst[23:10]), 14) * 4;
            default:       v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] ref_imm(logic [2:0] op, logic [31:0] inst);
        longint v;
        v = ref_val(op, inst);
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] ref_target(logic [2:0] op, logic [31:0] inst,
                                                     logic [TAG_W-1:0] tag);
        longint t;
        if (op == IMM_OP_SI16S2 || op == IMM_OP_SI26S2 || op == IMM_OP_SI20U) begin
            t = longint'(tag) + ref_val(op, inst);
            return t[DATA_W-1:0];
        end
        return '0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------------------------------------------------------------
    // Scoreboard: push on input transfer, pop/compare on output transfer.
    // Both sample at the falling edge, where inputs and registered outputs
    // are stable.
    // ---------------------------------------------------------------------
    always @(negedge cpu_clk) begin
        if (cpu_rst_n && !flush && bus.in_valid && bus.in_ready) begin
            exp_t e;
            e.imm    = ref_imm(bus.in_op, bus.in_inst);
            e.tag    = bus.in_tag;
            e.target = ref_target(bus.in_op, bus.in_inst, bus.in_tag);
            exp_q.push_back(e);
        end
    end

    always @(negedge cpu_clk) begin
        if (cpu_rst_n && flush) begin
            exp_q.delete();
        end
    end

    always @(negedge cpu_clk) begin
        if (cpu_rst_n && !flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=imm %h tag %h required=no output",
                         bus.out_imm, bus.out_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn imm=%h tag=%h", bus.out_imm, bus.out_tag);
                check("sb_imm", bus.out_imm, e.imm);
                check("sb_tag", bus.out_tag, e.tag);
`ifdef IMM_EXT_PCREL_EN
                check("sb_target", bus.out_target, e.target);
`endif
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver helpers. Called at #1 after a rising edge; return at #1 after
    // the edge where the word was accepted.
    // ---------------------------------------------------------------------
    task automatic send(input logic [2:0] op, input logic [31:0] inst,
                        input logic [TAG_W-1:0] tag, output int waited);
        logic acc;
        waited        = 0;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_inst   = inst;
        bus.in_tag    = tag;
        do begin
            @(negedge cpu_clk);
            acc = bus.in_ready;
            @(posedge cpu_clk);
            #1;
            waited++;
        end while (!acc && waited < 200);
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready low for %0d cycles required=accept", waited);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge cpu_clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=no finish required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Main stimulus
    // ---------------------------------------------------------------------
    initial begin
        int  w;
        bit  rand_done;

        bus.in_valid  = 1'b0;
        bus.in_op     = IMM_OP_NONE;
        bus.in_inst   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        rand_done     = 1'b0;

        // Reset state
        repeat (2) @(posedge cpu_clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_imm",   64'(bus.out_imm),   64'd0);
        check("rst_out_tag",   64'(bus.out_tag),   64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
`ifdef IMM_EXT_PCREL_EN
        check("rst_out_target", 64'(bus.out_target), 64'd0);
`endif
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk);
        #1;

        // One-cycle latency and the basic formats
        bus.out_ready = 1'b1;
        send(IMM_OP_SI12, 32'h02BFFC41, 32'h0000_1000, w);
        check("lat_si12_valid", 64'(bus.out_valid), 64'd1);
        check("lat_si12_imm",   64'(bus.out_imm),   64'hFFFF_FFFF);
        send(IMM_OP_UI12, 32'h02BFFC41, 32'h0000_1004, w);
        check("lat_ui12_imm",   64'(bus.out_imm),   64'h0000_0FFF);
        send(IMM_OP_SI26S2, 32'h03FF_FFFF, 32'h0000_1008, w);
        check("si26s2_imm",     64'(bus.out_imm),   64'hFFFF_FFFC);
        send(IMM_OP_SI20U, 32'h0100_0000, 32'h0000_100C, w);
        check("si20u_imm",      64'(bus.out_imm),   64'h8000_0000);
        wait_drain();

        // Backpressure: two accepted, third stalled until release
        @(posedge cpu_clk);
        #1;
        bus.out_ready = 1'b0;
        send(IMM_OP_SI12, 32'h0000_1400, 32'h0000_2000, w);
        send(IMM_OP_UI12, 32'h0000_2800, 32'h0000_2004, w);
        check("bp_in_ready_low", 64'(bus.in_ready),  64'd0);
        check("bp_out_valid",    64'(bus.out_valid), 64'd1);
        check("bp_head_imm",     64'(bus.out_imm),   64'd5);
        bus.in_valid = 1'b1;
        bus.in_op    = IMM_OP_SI16S2;
        bus.in_inst  = 32'h0000_0400;
        bus.in_tag   = 32'h0000_2008;
        repeat (2) begin
            @(posedge cpu_clk);
            #1;
        end
        check("bp_still_stalled", 64'(bus.in_ready), 64'd0);
        check("bp_hold_imm",      64'(bus.out_imm),  64'd5);
        check("bp_hold_tag",      64'(bus.out_tag),  64'h2000);
        bus.out_ready = 1'b1;
        send(IMM_OP_SI16S2, 32'h0000_0400, 32'h0000_2008, w);
        check("bp_third_wait_cycles", 64'(w), 64'd2);
        wait_drain();

        // Flush with both entries full and a pending input
        @(posedge cpu_clk);
        #1;
        bus.out_ready = 1'b0;
        send(IMM_OP_SI12, 32'h0000_0C00, 32'h0000_3000, w);
        send(IMM_OP_SI12, 32'h0000_1000, 32'h0000_3004, w);
        bus.in_valid = 1'b1;
        bus.in_op    = IMM_OP_UI12;
        bus.in_inst  = 32'h0000_1C00;
        bus.in_tag   = 32'h0000_3008;
        flush        = 1'b1;
        @(posedge cpu_clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(posedge cpu_clk);
            #1;
        end
        check("flush_nothing_left", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        send(IMM_OP_SI12, 32'h02BFFC41, 32'h0000_4000, w);
        check("arst_pre_valid", 64'(bus.out_valid), 64'd1);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_out_imm",   64'(bus.out_imm),   64'd0);
        check("arst_out_tag",   64'(bus.out_tag),   64'd0);
        check("arst_in_ready",  64'(bus.in_ready),  64'd1);
        exp_q.delete();
        @(posedge cpu_clk);
        #2;
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk);
        #1;

`ifdef IMM_EXT_PCREL_EN
        // PC-relative target
        bus.out_ready = 1'b1;
        send(IMM_OP_SI16S2, 32'h03FF_F000, 32'h1C00_0000, w);
        check("pcrel_imm",    64'(bus.out_imm),    64'hFFFF_FFF0);
        check("pcrel_target", 64'(bus.out_target), 64'h1BFF_FFF0);
        send(IMM_OP_SI12, 32'h02BFFC41, 32'h1C00_0000, w);
        check("pcrel_non_pc_target", 64'(bus.out_target), 64'd0);
        wait_drain();
`endif

        // Randomized stream with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge cpu_clk);
                        #1;
                    end
                    send(3'($urandom_range(0, 7)), $urandom, $urandom, w);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge cpu_clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
